// File: rtl/mips_ext_pkg.sv
// Shared types for the MIPS immediate-extension path: extension modes and
// the storage-state encoding used by the pipelined extender.
package mips_ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_SEXT      = 2'd0;
    localparam ext_mode_t EXT_ZEXT      = 2'd1;
    localparam ext_mode_t EXT_UPPER     = 2'd2;
    localparam ext_mode_t EXT_SEXT_SHL2 = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } store_state_t;

    // True when the output is wide enough to hold a sign-extended value shifted by 2.
    function automatic bit ext_width_ok(input int in_w, input int out_w);
        return out_w >= in_w + 2;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; shared by the pipelined extender and the
// ALU-immediate path.
module imm_ext_core
    import mips_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] data
);

    localparam int PAD_W = OUT_W - IN_W;

    if (!ext_width_ok(IN_W, OUT_W)) begin : g_bad_width
        $error("imm_ext_core: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] upper_val;
    logic [OUT_W-1:0] shl2_val;

    assign sext_val  = {{PAD_W{imm[IN_W-1]}}, imm};
    assign zext_val  = {{PAD_W{1'b0}}, imm};
    assign upper_val = {imm, {PAD_W{1'b0}}};
    // Dropping the top two sign copies loses nothing given the width guarantee.
    assign shl2_val  = {sext_val[OUT_W-3:0], 2'b00};

    always_comb begin
        data = sext_val;
        case (mode)
            EXT_SEXT:      data = sext_val;
            EXT_ZEXT:      data = zext_val;
            EXT_UPPER:     data = upper_val;
            EXT_SEXT_SHL2: data = shl2_val;
            default:       data = sext_val;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: one-cycle latency, valid/ready handshake with
// an output register plus one skid slot so decode can keep issuing under stall.
module imm_extend_pipe
    import mips_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (TAG_W < 1) begin : g_bad_tag
        $error("imm_extend_pipe: TAG_W must be at least 1");
    end

    logic [OUT_W-1:0] ext_data;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    store_state_t     state_q, state_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;

    logic accept;
    logic drain;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_data_d = ext_data;
                    out_tag_d  = in_tag;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_data_d = ext_data;
                    out_tag_d  = in_tag;
                end else if (accept) begin
                    skid_data_d = ext_data;
                    skid_tag_d  = in_tag;
                    state_d     = ST_TWO;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the skid-to-output move can happen.
                if (drain) begin
                    out_data_d = skid_data_q;
                    out_tag_d  = skid_tag_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: FIFO reference model checked every cycle, plus
// directed streams compared against hand-computed results.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension by plain arithmetic on the immediate's numeric value.
    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint u = longint'(imm);
        longint s = (imm >= 16'h8000) ? u - 65536 : u;
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(u);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    // Model: a queue of items in flight; ready while fewer than two are held.
    logic [35:0] mq[$];
    logic [35:0] got[$];
    logic [31:0] hold_data = '0;
    logic [3:0]  hold_tag = '0;
    bit          up = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit acc, drn;
        started = 1'b1;
        if (!rst_n) begin
            mq.delete();
            up = 1'b0;
            hold_data = '0;
            hold_tag = '0;
        end else begin
            acc = in_valid && up && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({in_tag, model_ext(in_imm, in_mode)});
            up = 1'b1;
            if (mq.size() > 0) begin
                hold_data = mq[0][31:0];
                hold_tag  = mq[0][35:32];
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(up && (mq.size() < 2)));
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0][31:0]);
                chk("out_tag", 32'(out_tag), 32'(mq[0][35:32]));
            end else begin
                chk("idle_data", out_data, hold_data);
                chk("idle_tag", 32'(out_tag), 32'(hold_tag));
            end
            if (out_valid && out_ready) got.push_back({out_tag, out_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until it is accepted (bounded).
    task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [3:0] tag);
        bit acc;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        for (int n = 0; n < 20; n++) begin
            acc = in_ready;
            tick();
            if (acc) return;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_until_empty();
        in_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!out_valid) return;
            tick();
        end
        chk("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    task automatic chk_got(input string name, input int idx, input logic [31:0] d, input logic [3:0] t);
        if (idx < got.size()) begin
            chk(name, got[idx][31:0], d);
            chk(name, 32'(got[idx][35:32]), 32'(t));
        end else begin
            chk({name, "_missing"}, 32'(got.size()), 32'(idx + 1));
        end
    endtask

    logic [15:0] s1_in[7]  = '{16'h0000, 16'h0005, 16'h3018, 16'hFF85, 16'hFEA7, 16'hFFFF, 16'h0003};
    logic [31:0] s1_out[7] = '{32'h00000000, 32'h00000005, 32'h00003018, 32'hFFFFFF85,
                               32'hFFFFFEA7, 32'hFFFFFFFF, 32'h00000003};
    logic [15:0] s2_in[5]  = '{16'hFFFF, 16'h1234, 16'hFFFF, 16'h0003, 16'h8000};
    logic [1:0]  s2_md[5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] s2_out[5] = '{32'h0000FFFF, 32'h12340000, 32'hFFFFFFFC, 32'h0000000C, 32'hFFFE0000};

    initial begin
        logic [31:0] snap;

        // Pin the model itself to hand-computed values.
        for (int i = 0; i < 7; i++) chk("model_sext", model_ext(s1_in[i], 2'd0), s1_out[i]);
        for (int i = 0; i < 5; i++) chk("model_mode", model_ext(s2_in[i], s2_md[i]), s2_out[i]);

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // 1: SEXT stream, back-to-back
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 7; i++) send(s1_in[i], 2'd0, 4'(i));
        idle_until_empty();
        for (int i = 0; i < 7; i++) chk_got("sext_stream", i, s1_out[i], 4'(i));

        // 2: other modes
        got.delete();
        for (int i = 0; i < 5; i++) send(s2_in[i], s2_md[i], 4'(8 + i));
        idle_until_empty();
        for (int i = 0; i < 5; i++) chk_got("modes", i, s2_out[i], 4'(8 + i));

        // 3: backpressure with A, B, C
        got.delete();
        out_ready = 1'b0;
        send(16'h00AA, 2'd1, 4'hA);
        send(16'h00BB, 2'd1, 4'hB);
        in_imm = 16'h00CC;
        in_tag = 4'hC;
        tick();
        tick();
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_hold_a", out_data, 32'h000000AA);
        chk("bp_hold_tag", 32'(out_tag), 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        send(16'h00CC, 2'd1, 4'hC);
        idle_until_empty();
        chk_got("bp_order", 0, 32'h000000AA, 4'hA);
        chk_got("bp_order", 1, 32'h000000BB, 4'hB);
        chk_got("bp_order", 2, 32'h000000CC, 4'hC);

        // 4: accept and drain every cycle
        got.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_imm  = 16'(16'h8000 + i);
            in_mode = 2'(i);
            in_tag  = 4'(i);
            chk("tput_ready", 32'(in_ready), 32'd1);
            tick();
        end
        idle_until_empty();
        chk("tput_count", 32'(got.size()), 32'd10);

        // 5: reset while two items are held
        got.delete();
        out_ready = 1'b0;
        send(16'h1111, 2'd0, 4'h1);
        send(16'h2222, 2'd0, 4'h2);
        in_valid = 1'b0;
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_tag", 32'(out_tag), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("no_ghost_items", 32'(got.size()), 32'd0);

        // 6: idle with junk on the inputs
        send(16'h4321, 2'd2, 4'h7);
        idle_until_empty();
        snap = out_data;
        chk("idle_snap", snap, 32'h43210000);
        for (int i = 0; i < 5; i++) begin
            in_imm  = 16'($urandom);
            in_mode = 2'($urandom);
            in_tag  = 4'($urandom);
            tick();
            chk("idle_no_valid", 32'(out_valid), 32'd0);
        end
        chk("idle_stable", out_data, snap);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the MIPS datapath. It is the successor to the fixed 16→32 sign extender and adds:
- selectable extension modes (sign, zero, upper/LUI, sign-extend with shift-left-2 for branch offsets);
- generic input and output widths;
- a valid/ready handshake with a 2-entry skid buffer, so it can sit between decode and execute under stall backpressure.

A sideband tag travels with each item for pipeline bookkeeping.

Parameters:
- IN_W, 16, immediate input width in bits.
- OUT_W, 32, extended output width. Must satisfy OUT_W ≥ IN_W+2; elaboration fails otherwise.
- TAG_W, 4, width of the pass-through sideband tag. Minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has an item.
- in_ready  out  1  block can accept an item this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  extension mode (encoding in package).
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  out_data/out_tag hold a valid item.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of the item on out_data.

Behaviour:
Clock and reset:
- One clock, clk.
- rst_n is synchronous and active-low: it is sampled only on the rising edge of clk.

Reset (rst_n low at a clk edge):
- out_valid=0, out_data=0, out_tag=0.
- Skid buffer emptied.
- in_ready=0 while rst_n is low; in_ready=1 on the first edge after rst_n goes high.
- Reset mid-operation discards all held items with no partial output.

Modes (2-bit):
- SEXT=0: out = in_imm sign-extended to OUT_W.
- ZEXT=1: out = in_imm zero-extended.
- UPPER=2: out = in_imm << (OUT_W-IN_W), low bits zero.
- SEXT_SHL2=3: out = sign-extended in_imm shifted left 2. This is lossless because OUT_W ≥ IN_W+2.

Handshake:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.
- Extension is computed combinationally at input acceptance and registered.
- Latency: 1 cycle. An item accepted at edge N is on out_data after edge N.
- Storage states: EMPTY, ONE (output register valid), TWO (output register plus skid valid).
  - in_ready = registered "skid empty", so in_ready=0 only in TWO.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → TWO (new item goes to skid).
  - ONE + accept + drain → ONE (new item goes to output register).
  - ONE + drain only → EMPTY.
  - TWO + drain → ONE (skid moves to output register; no accept possible since in_ready=0).
  - TWO, no drain → TWO (hold).
- Order is strictly FIFO; no item is lost or duplicated.
- out_data/out_tag stay stable while out_valid && !out_ready.
- Throughput: 1 item/cycle when out_ready is held high.
- in_mode, in_imm and in_tag are don't-care when in_valid=0. The output register is not updated on a cycle with no accept.

Decomposition:
- Package mips_ext_pkg:
  - 2-bit mode type.
  - Localparams EXT_SEXT, EXT_ZEXT, EXT_UPPER, EXT_SEXT_SHL2.
  - Storage-state encoding EMPTY/ONE/TWO.
- Sub-module imm_ext_core: purely combinational extender (IN_W, OUT_W, mode → data), reusable by the ALU-immediate path.
- imm_extend_pipe itself holds the handshake, output register and skid.

Test Plan (IN_W=16, OUT_W=32, TAG_W=4):
1. SEXT stream with out_ready=1: 0x0000, 0x0005, 0x3018, 0xFF85, 0xFEA7, 0xFFFF, 0x0003 → 0x00000000, 0x00000005, 0x00003018, 0xFFFFFF85, 0xFFFFFEA7, 0xFFFFFFFF, 0x00000003. Each appears 1 cycle after acceptance, back-to-back, tags 0..6 echoed.
2. Modes on 0xFFFF and 0x1234:
   - ZEXT → 0x0000FFFF.
   - UPPER 0x1234 → 0x12340000.
   - SEXT_SHL2 0xFFFF → 0xFFFFFFFC.
   - SEXT_SHL2 0x0003 → 0x0000000C.
   - SEXT_SHL2 0x8000 → 0xFFFE0000.
3. Backpressure: out_ready=0 for 4 cycles while offering A,B,C continuously.
   - A is held stable on out_data, B is in the skid, in_ready=0 and C is not accepted.
   - out_ready=1 → A, B, C delivered in order on consecutive cycles; in_ready returns to 1 one cycle after the first drain.
4. Simultaneous accept and drain in ONE state: out_ready=1, in_valid=1 every cycle for 10 cycles → 10 outputs, in_ready never drops.
5. Reset mid-operation: reach TWO, pull rst_n low for 1 cycle.
   - Next edge: out_valid=0, out_data=0, out_tag=0, in_ready=0.
   - in_ready=1 the cycle after rst_n goes high.
   - Neither held item ever appears on the output.
6. Idle: in_valid=0 for 5 cycles with random in_imm → out_valid stays 0 and out_data is unchanged.
